// File: rtl/mem_block_mover_if.sv
// Command and memory-bus bundle for the block mover.
// master: the mover (accepts commands, drives the memory port).
// slave:  the surrounding control logic plus the data memory.
interface mem_block_mover_if #(
    parameter int DEPTH_LOG2 = 8
);
    logic                  start;
    logic                  op;
    logic [DEPTH_LOG2-1:0] src;
    logic [DEPTH_LOG2-1:0] dst;
    logic [DEPTH_LOG2:0]   len;
    logic [31:0]           pattern;
    logic                  busy;
    logic                  done;
    logic [DEPTH_LOG2:0]   words_done;
    logic [31:0]           mem_address;
    logic                  mem_we;
    logic [31:0]           mem_write_data;
    logic [31:0]           mem_read_data;

    modport master (
        input  start, op, src, dst, len, pattern, mem_read_data,
        output busy, done, words_done, mem_address, mem_we, mem_write_data
    );

    modport slave (
        output start, op, src, dst, len, pattern, mem_read_data,
        input  busy, done, words_done, mem_address, mem_we, mem_write_data
    );
endinterface

// File: rtl/mem_block_mover.sv
// Block copy / fill engine for a single-port memory with combinational reads.
// Copy costs RD+WR per word, fill costs one WR per word. All bus outputs are
// registered from the next-state values so they are stable for a whole cycle.
module mem_block_mover #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic               clk,
    input  logic               rst,
    mem_block_mover_if.master  bus
);
    localparam int AW = DEPTH_LOG2;
    localparam logic [AW:0] ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          op_q, op_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW:0]   len_q, len_d;
    logic [31:0]   pat_q, pat_d;
    logic [31:0]   data_q, data_d;
    logic [AW:0]   idx_q, idx_d;        // also serves as words_done
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    // Next-state, command latching, and bus outputs decoded from the next state.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        pat_d   = pat_q;
        data_d  = data_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    src_d = bus.src;
                    dst_d = bus.dst;
                    len_d = bus.len;
                    pat_d = bus.pattern;
                    idx_d = '0;
                    if (bus.len == '0)  state_d = S_DONE;
                    else if (!bus.op)   state_d = S_RD;
                    else                state_d = S_WR;
                end
            end
            S_RD: begin
                data_d  = bus.mem_read_data;
                state_d = S_WR;
            end
            S_WR: begin
                idx_d = idx_q + ONE;
                if (idx_q + ONE == len_q) state_d = S_DONE;
                else if (!op_q)           state_d = S_RD;
                else                      state_d = S_WR;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d == S_RD) || (state_d == S_WR);
        done_d  = (state_d == S_DONE);
        we_d    = (state_d == S_WR);
        addr_d  = '0;
        wdata_d = '0;
        if (state_d == S_RD) begin
            addr_d = src_d + idx_d[AW-1:0];
        end else if (state_d == S_WR) begin
            addr_d  = dst_d + idx_d[AW-1:0];
            wdata_d = op_d ? pat_d : data_d;
        end
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.words_done     = idx_q;
    assign bus.mem_address    = 32'(addr_q);
    // The memory commits on the same edge that resets us, so the write enable
    // is masked by rst to keep an aborted word from landing.
    assign bus.mem_we         = we_q & ~rst;
    assign bus.mem_write_data = wdata_q;
endmodule

// File: doc/mem_block_mover.md
# mem_block_mover

Bus-master engine that drives the single-port 256×32 data memory's `address`/`we`/`write_data`/`read_data` port. It accepts one command (copy a block, or fill a block with a constant) and sequences the memory accesses itself. It sits between the MCU control logic and the data memory, and is the initiator for the memory's responder port. Memory read data is combinational, so a read completes in the same cycle its address is presented.

## Interface
Parameters:
- `DEPTH_LOG2`, 8: memory word-address width. The memory holds 2^8 = 256 words.

Ports:
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  command strobe. Sampled only in IDLE.
- `op`  in  1  operation: 0 = copy, 1 = fill.
- `src`  in  8  source word address (copy only).
- `dst`  in  8  destination word address.
- `len`  in  9  number of words to transfer, 0..256.
- `pattern`  in  32  fill value (fill only).
- `busy`  out  1  high from the cycle after acceptance until DONE.
- `done`  out  1  one-cycle pulse when the command completes.
- `words_done`  out  9  count of words written so far for the current command.
- `mem_address`  out  32  word address to the memory. Bits [31:8] are always 0.
- `mem_we`  out  1  memory write enable.
- `mem_write_data`  out  32  memory write data.
- `mem_read_data`  in  32  memory read data (combinational from `mem_address`).

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE:
  - When `start`=1, latch `op`, `src`, `dst`, `len`, `pattern`, and clear the index `i` and `words_done` to 0.
  - Next state:
    - if `len`=0: DONE;
    - else if `op`=0: RD;
    - else: WR.
- RD (copy only):
  - Drive `mem_address` = `src`+`i` (mod 256) and `mem_we`=0.
  - Capture `mem_read_data` into the data register at the clock edge.
  - Next state: WR.
- WR:
  - Drive `mem_address` = `dst`+`i` (mod 256) and `mem_we`=1.
  - `mem_write_data` = the data register (copy) or the latched `pattern` (fill).
  - At the clock edge, increment `i` and `words_done`.
  - Next state:
    - if `i`+1 = latched `len`: DONE;
    - else if copy: RD;
    - else: WR.
- DONE:
  - `done`=1 and `busy`=0 for this cycle.
  - Next state: IDLE.
- In IDLE and DONE, `mem_we`=0 and `mem_address`=0.
- `start` asserted while not in IDLE is ignored; it is not queued.
- Address arithmetic is 8-bit and wraps modulo 256. `src`=250 with `len`=10 reads words 250..255 and then 0..3.
- Overlapping copies are strictly ascending, read-before-write per word. With `dst` = `src`+1, the first source word propagates through the whole block. This is defined behaviour.
- `len`=256 transfers every word exactly once.
- `words_done` holds its final value through DONE and IDLE until the next accepted `start`.

## Timing
- Reset (`rst`=1 at an edge) forces the following, regardless of state:
  - state IDLE;
  - `busy`=0, `done`=0, `words_done`=0;
  - `mem_we`=0, `mem_address`=0, `mem_write_data`=0.
- Reset in the middle of a command aborts it at that edge. No further writes occur, and `done` is not pulsed.
- Start accepted at edge k: `busy`=1 from cycle k+1.
- Per-word cost is 2 cycles for copy and 1 cycle for fill.
- `done` is high in the cycle after the last WR:
  - copy: `done` at cycle k+1+2·`len`;
  - fill: `done` at cycle k+1+`len`;
  - `len`=0: `done` at cycle k+1, with no memory access.
- The earliest next `start` is accepted on the edge that ends the DONE cycle (IDLE follows).
- `mem_*` outputs come directly from state and registers, so they are stable for the whole cycle.

## Test plan
- Fill:
  - Stimulus: `op`=1, `dst`=0x10, `len`=4, `pattern`=0xDEADBEEF.
  - Required: 4 consecutive `mem_we` cycles at addresses 0x10..0x13. `done` 5 cycles after acceptance. Memory words 0x10..0x13 = 0xDEADBEEF; 0x0F and 0x14 are unchanged. `words_done`=4.
- Copy:
  - Stimulus: preload memory words 0..2 with 0x11, 0x22, 0x33, then copy `src`=0, `dst`=0x80, `len`=3.
  - Required: the RD/WR alternation shows on the bus. Memory words 0x80..0x82 = 0x11, 0x22, 0x33. `done` at cycle k+7.
- Wrap and full length:
  - Stimulus 1: fill `dst`=0xFE, `len`=4 with 0xA5A5A5A5.
  - Required 1: words 0xFE, 0xFF, 0x00, 0x01 are written, and `mem_address`[31:8] stays 0 throughout.
  - Stimulus 2: fill with `len`=256.
  - Required 2: all 256 words are written, and `done` is at cycle k+257.
- Zero length and ignored start:
  - Stimulus 1: `len`=0.
  - Required 1: `done` at k+1, no `mem_we` pulse.
  - Stimulus 2: during a copy, pulse `start` with different arguments.
  - Required 2: the running command is unaffected, and no second command executes.
- Overlapping copy:
  - Stimulus: words 0..3 = 1, 2, 3, 4; copy `src`=0, `dst`=1, `len`=3.
  - Required: words 1..3 = 1, 1, 1.
- Reset mid-command:
  - Stimulus: assert `rst` during the third WR of a `len`=8 fill.
  - Required: that word is not written (the edge where `rst`=1 takes priority over the write). `busy`=0, `mem_we`=0, `words_done`=0 from the next cycle. No `done` pulse. A fresh command afterwards runs normally.
